// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer driving a shared 1-bit output-select slice (optional ovf output via ALU_SERIAL_OVF_EN)
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [5:0]       slice_sel,
  output logic             slice_and,
  output logic             slice_or,
  output logic             slice_fa,
  output logic             slice_slt,
  input  logic             slice_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic             illegal
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_SLT = 6'd42;
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, nxt;
  logic [WIDTH-1:0] a, b, result;
  logic [IW-1:0] idx;
  logic carry, set, v;
  logic a_i, b_i, maj, sum, accept, inv_in;

  function automatic logic is_legal(input logic [5:0] f);
    return f == F_ADD || f == F_SUB || f == F_AND || f == F_OR || f == F_SLT;
  endfunction

  assign busy   = (state != IDLE) || done;
  assign accept = start && !busy;
  assign inv_in = funct == F_SUB || funct == F_SLT;
  assign a_i    = a[idx];
  assign b_i    = b[idx];
  assign sum    = a_i ^ b_i ^ carry;
  assign maj    = (a_i & b_i) | (carry & (a_i ^ b_i));

  // state register; async reset aborts any in-flight operation
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;

  // next state: unsupported ops skip straight to DONE, SLT takes one extra FIX cycle
  always_comb begin
    nxt = state == IDLE ? (accept ? (is_legal(funct) ? RUN : DONE) : IDLE)
        : state == RUN  ? (idx == LAST ? (slice_sel == F_SLT ? FIX : DONE) : RUN)
        : state == FIX  ? DONE
        : IDLE;
  end

  // slice candidate bits; all zero outside RUN/FIX
  always_comb begin
    slice_and = state == RUN && (a_i & b_i);
    slice_or  = state == RUN && (a_i | b_i);
    slice_fa  = state == RUN && sum;
    slice_slt = state == FIX && set;
  end

  // operand capture, bit-serial datapath and result publication
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a         <= '0;
      b         <= '0;
      result    <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      set       <= 1'b0;
      v         <= 1'b0;
      slice_sel <= '0;
      done      <= 1'b0;
      dataOut   <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      done <= state == DONE;
      if (state == IDLE && accept) begin
        a         <= dataA;
        b         <= inv_in ? ~dataB : dataB;
        carry     <= inv_in;
        idx       <= '0;
        result    <= '0;
        slice_sel <= funct;
      end
      if (state == RUN) begin
        result[idx] <= slice_out;
        carry       <= maj;
        idx         <= idx == LAST ? '0 : idx + IW'(1);
        if (idx == LAST) begin
          v   <= carry ^ maj;
          set <= sum ^ carry ^ maj;
        end
      end
      if (state == FIX) result <= {{(WIDTH-1){1'b0}}, slice_out};
      if (state == DONE) begin
        dataOut <= result;
        zero    <= result == '0;
        illegal <= !is_legal(slice_sel);
`ifdef ALU_SERIAL_OVF_EN
        ovf     <= (slice_sel == F_ADD || slice_sel == F_SUB) && v;
`endif
      end
    end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: randomized self-checking bench for alu_serial_ctrl with a behavioural slice and word-level model
module tb_alu_serial_ctrl;
  localparam int W = 32;
  logic clk = 0, rst = 1, start = 0;
  logic [5:0] funct = '0;
  logic [W-1:0] dataA = '0, dataB = '0;
  logic [5:0] slice_sel;
  logic slice_and, slice_or, slice_fa, slice_slt, slice_out;
  logic busy, done, zero, illegal;
  logic [W-1:0] dataOut;
`ifdef ALU_SERIAL_OVF_EN
  logic ovf;
`endif
  int n_chk = 0, n_err = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .dataA(dataA), .dataB(dataB),
    .slice_sel(slice_sel), .slice_and(slice_and), .slice_or(slice_or), .slice_fa(slice_fa),
    .slice_slt(slice_slt), .slice_out(slice_out), .busy(busy), .done(done), .dataOut(dataOut),
    .zero(zero), .illegal(illegal)
`ifdef ALU_SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // 1-bit output-select slice: combinational mux on funct code
  always_comb begin
    slice_out = slice_sel == 6'd36 ? slice_and
              : slice_sel == 6'd37 ? slice_or
              : (slice_sel == 6'd32 || slice_sel == 6'd34) ? slice_fa
              : slice_sel == 6'd42 ? slice_slt
              : 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    logic [W-1:0] er;
    bit il, eo;
    int lat, n;
    il = 0;
    eo = 0;
    case (f)
      6'd32: begin er = a + b; eo = (a[W-1] == b[W-1]) && (er[W-1] != a[W-1]); end
      6'd34: begin er = a - b; eo = (a[W-1] != b[W-1]) && (er[W-1] != a[W-1]); end
      6'd36: er = a & b;
      6'd37: er = a | b;
      6'd42: er = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin er = '0; il = 1; end
    endcase
    lat = il ? 1 : (f == 6'd42 ? W + 2 : W + 1);
    start = 1; funct = f; dataA = a; dataB = b;
    @(posedge clk); #1;
    start = 0; dataA = $urandom; dataB = $urandom; funct = 6'($urandom);
    check("busy_acc", 64'(busy), 1);
    check("sel_acc", 64'(slice_sel), 64'(f));
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 10) begin start = 1; funct = 6'd37; dataA = '1; dataB = '1; end
      if (poke && n == 11) start = 0;
    end
    check("latency", 64'(n), 64'(lat));
    check("dataOut", 64'(dataOut), 64'(er));
    check("zero", 64'(zero), 64'(er == 0));
    check("illegal", 64'(illegal), 64'(il));
`ifdef ALU_SERIAL_OVF_EN
    check("ovf", 64'(ovf), 64'(eo));
`endif
    check("busy_done", 64'(busy), 1);
    check("slices_done", 64'({slice_and, slice_or, slice_fa, slice_slt}), 0);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 0);
    check("busy_after", 64'(busy), 0);
    check("dataOut_hold", 64'(dataOut), 64'(er));
  endtask

  initial begin
    logic [5:0] fl [5];
    fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'({busy, done, zero, illegal, slice_sel}), 0);
    check("rst_data", 64'(dataOut), 0);
    rst = 0;
    @(posedge clk); #1;
    run_op(6'd32, 5, 3, 0);
    run_op(6'd34, 7, 7, 0);
    run_op(6'd32, 32'h7FFFFFFF, 1, 0);
    run_op(6'd42, 32'hFFFFFFFF, 1, 0);
    run_op(6'd42, 32'h7FFFFFFF, 32'h80000000, 0);
    run_op(6'd36, 32'hF0F0F0F0, 32'hFF00FF00, 1);
    run_op(6'd37, 32'hF0F0F0F0, 32'hFF00FF00, 1);
    run_op(6'd0, 32'h12345678, 32'h9ABCDEF0, 0);
    run_op(6'd34, 32'h80000000, 1, 0);
    start = 1; funct = 6'd32; dataA = 32'd100; dataB = 32'd23;
    @(posedge clk); #1;
    start = 0;
    repeat (14) @(posedge clk);
    #1 rst = 1;
    #1;
    check("midrst_state", 64'({busy, done, zero, illegal, slice_sel}), 0);
    check("midrst_slices", 64'({slice_and, slice_or, slice_fa, slice_slt}), 0);
    check("midrst_data", 64'(dataOut), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_nodone", 64'(done), 0);
    end
    rst = 0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(busy), 0);
    run_op(6'd32, 32'd100, 32'd23, 0);
    for (int i = 0; i < 30; i++) begin
      logic [5:0] f;
      logic [W-1:0] a, b;
      int k;
      k = $urandom_range(0, 5);
      f = k == 5 ? 6'($urandom) : fl[k];
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      run_op(f, a, b, $urandom_range(0, 1) == 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial ALU sequencer that sits directly upstream of the 1-bit ALU output-select slice. It accepts one 32-bit operation (AND/OR/ADD/SUB/SLT by MIPS funct code), and drives the slice one bit per cycle with its select code and the four candidate inputs (AND, OR, full-adder sum, SLT). It captures the slice's output bit into a result register, then presents the full word with done/zero flags. This replaces a 32-slice ripple array with one shared slice plus sequencing.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- funct  input  6  operation: 36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT
- dataA, dataB  input  WIDTH  operands, sampled on accepted start
- slice_sel  output  6  select code to slice (latched funct)
- slice_and, slice_or, slice_fa, slice_slt  output  1 each  candidate bits for current bit
- slice_out  input  1  selected bit returned by slice (combinational path)
- busy  output  1  high from accept until end of done cycle
- done  output  1  one-cycle pulse, result valid
- dataOut  output  WIDTH  result, held until next accepted start
- zero  output  1  dataOut==0, updated with done
- illegal  output  1  funct not in supported set, updated with done

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 latches dataA, funct; latches B = funct∈{SUB,SLT} ? ~dataB : dataB; carry = funct∈{SUB,SLT}; idx=0; clears result → RUN. Unsupported funct → DONE directly with dataOut=0, illegal=1.
- RUN, bit i=idx: slice_and=A[i]&B[i], slice_or=A[i]|B[i], slice_fa=A[i]^B[i]^carry, slice_slt=0. On clock: result[i]←slice_out, carry←majority(A[i],B[i],carry), idx++. After i=WIDTH-1: SLT → FIX, else → DONE. Records set = sum[MSB] ^ overflow (overflow = carry-in[MSB] ^ carry-out[MSB]).
- FIX (SLT only): idx=0, slice_slt=set, slice_and/or/fa=0; result←{0…0, slice_out}; → DONE.
- DONE: dataOut←result, zero, illegal registered; done=1 for exactly this cycle; → IDLE.
- slice_* outputs are 0 in IDLE and DONE; slice_sel holds the latched funct from accept through DONE, 0 after reset.
- start while busy: ignored, no effect on in-flight operation.
- Arithmetic modulo 2^WIDTH; carry out of MSB discarded.

## Timing
- Reset (async): state=IDLE; busy, done, zero, illegal, dataOut, slice_sel, idx, carry, result all 0. Reset mid-operation aborts with no done pulse.
- start accepted at edge 0 → RUN covers edges 1..WIDTH; done high in the cycle after edge WIDTH+1 (non-SLT), edge WIDTH+2 (SLT). Illegal: done in cycle after edge 1.
- Throughput: new start accepted in the cycle immediately after done (busy=0 in IDLE).
- slice_out sampled same cycle it is driven; slice is purely combinational, no pipeline register between.

## Configuration
- ALU_SERIAL_OVF_EN defined: adds output ovf (1 bit), registered with done: signed overflow for ADD/SUB, 0 for AND/OR/SLT/illegal; reset 0. Undefined: port and logic absent, behaviour otherwise identical.

## Test plan
- ADD 5+3 (funct 32), WIDTH=32 → done pulse cycle after edge 33, dataOut=8, zero=0, illegal=0.
- SUB 7−7 (funct 34) → dataOut=0, zero=1; with ALU_SERIAL_OVF_EN, ADD 0x7FFFFFFF+1 → dataOut=0x80000000, ovf=1.
- SLT 0xFFFFFFFF vs 1 (funct 42) → dataOut=1, done after edge 34; SLT 0x7FFFFFFF vs 0x80000000 → dataOut=0 (overflow-corrected).
- AND/OR 0xF0F0F0F0, 0xFF00FF00 → 0xF000F000 / 0xFFF0FFF0; start pulsed at edge 10 mid-run ignored, result unchanged.
- funct 0 → done after edge 1, illegal=1, dataOut=0, zero=1.
- rst asserted at edge 15 of an ADD → all outputs 0 immediately, no done; next start after rst release completes normally.
